// File: rtl/melody_player.sv
// Table-driven melody sequencer: fetches {half_period, dur_ms} words from a synchronous
// note memory and plays them as a square wave on speaker, with rests, end marker, loop and stop.
module melody_player #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned HP_W     = 20,
  parameter int unsigned DUR_W    = 12,
  parameter int unsigned GAP_MS   = 100
) (
  input  logic                   clk_50MHz,
  input  logic                   rst_n,
  input  logic                   play,
  input  logic                   stop,
  input  logic                   loop,
  output logic [ADDR_W-1:0]      note_addr,
  output logic                   note_rd,
  input  logic [HP_W+DUR_W-1:0]  note_data,
  output logic                   speaker,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned TICKS_PER_MS = CLK_FREQ / 1000;
  localparam int unsigned PS_W         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int unsigned GAP_LAST     = (GAP_MS > 0) ? GAP_MS - 1 : 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_NOTE  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              spk_nxt, done_nxt;
  logic [PS_W-1:0]   ps, ps_nxt;
  logic [DUR_W-1:0]  ms, ms_nxt, ms_inc;
  logic [HP_W-1:0]   tc, tc_nxt;
  logic [HP_W-1:0]   hp_q, hp_nxt;
  logic [DUR_W-1:0]  dur_q, dur_nxt;
  logic              loop_q, loop_nxt;
  logic              advance;
  logic              tick, note_end, gap_end;
  logic [HP_W-1:0]   data_hp;
  logic [DUR_W-1:0]  data_dur;

  // play synchroniser; armed only once the synced level has been seen low after reset,
  // so a button held through reset release does not count as a start
  logic [2:0] sync;
  logic       sync_d;
  logic [1:0] fill;
  logic       armed;
  logic       start;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
      fill   <= '0;
      armed  <= 1'b0;
    end else begin
      sync   <= {sync[1:0], play};
      sync_d <= sync[2];
      if (fill != 2'd3)
        fill <= fill + 2'd1;
      if (fill == 2'd3 && !sync[2])
        armed <= 1'b1;
    end
  end

  assign start = armed & sync[2] & ~sync_d;

  assign data_hp  = note_data[HP_W+DUR_W-1 -: HP_W];
  assign data_dur = note_data[DUR_W-1:0];

  assign tick     = (ps == PS_W'(TICKS_PER_MS - 1));
  assign ms_inc   = (ms == '1) ? ms : ms + DUR_W'(1);
  assign note_end = tick && (ms == dur_q - DUR_W'(1));
  assign gap_end  = tick && (ms == DUR_W'(GAP_LAST));

  // state register
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // next-state, next-output and counter update
  always_comb begin
    state_nxt = state;
    addr_nxt  = note_addr;
    spk_nxt   = 1'b0;
    done_nxt  = 1'b0;
    ps_nxt    = ps;
    ms_nxt    = ms;
    tc_nxt    = tc;
    hp_nxt    = hp_q;
    dur_nxt   = dur_q;
    loop_nxt  = loop_q;
    advance   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FETCH;
          addr_nxt  = '0;
        end
      end
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD: begin
        hp_nxt   = data_hp;
        dur_nxt  = data_dur;
        loop_nxt = loop;
        if (data_dur == '0) begin
          if (loop) begin
            addr_nxt  = '0;
            state_nxt = S_FETCH;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          state_nxt = S_NOTE;
          ps_nxt    = '0;
          ms_nxt    = '0;
          tc_nxt    = '0;
        end
      end
      S_NOTE: begin
        ps_nxt = tick ? '0 : ps + PS_W'(1);
        ms_nxt = tick ? ms_inc : ms;
        if (note_end) begin
          if (GAP_MS != 0) begin
            state_nxt = S_GAP;
            ps_nxt    = '0;
            ms_nxt    = '0;
          end else begin
            advance = 1'b1;
          end
        end else if (hp_q != '0) begin
          spk_nxt = speaker;
          if (tc >= hp_q - HP_W'(1)) begin
            tc_nxt  = '0;
            spk_nxt = ~speaker;
          end else begin
            tc_nxt = tc + HP_W'(1);
          end
        end
      end
      S_GAP: begin
        ps_nxt = tick ? '0 : ps + PS_W'(1);
        ms_nxt = tick ? ms_inc : ms;
        if (gap_end)
          advance = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    // last address without an end marker behaves like one
    if (advance) begin
      if (note_addr == '1) begin
        if (loop_q) begin
          addr_nxt  = '0;
          state_nxt = S_FETCH;
        end else begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end else begin
        addr_nxt  = note_addr + ADDR_W'(1);
        state_nxt = S_FETCH;
      end
    end

    if (stop) begin
      state_nxt = S_IDLE;
      addr_nxt  = note_addr;
      spk_nxt   = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  // registered outputs and datapath
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      note_addr <= '0;
      note_rd   <= 1'b0;
      speaker   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ps        <= '0;
      ms        <= '0;
      tc        <= '0;
      hp_q      <= '0;
      dur_q     <= '0;
      loop_q    <= 1'b0;
    end else begin
      note_addr <= addr_nxt;
      note_rd   <= (state_nxt == S_FETCH);
      speaker   <= spk_nxt;
      busy      <= (state_nxt != S_IDLE);
      done      <= done_nxt;
      ps        <= ps_nxt;
      ms        <= ms_nxt;
      tc        <= tc_nxt;
      hp_q      <= hp_nxt;
      dur_q     <= dur_nxt;
      loop_q    <= loop_nxt;
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Bench for melody_player: a song-level timeline model predicts every output per cycle,
// plus literal pins on the model and directed reset/stop cases.
module tb_melody_player;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned HP_W   = 20;
  localparam int unsigned DUR_W  = 12;
  localparam int TPM  = 100;
  localparam int GAP  = 1;
  localparam int MAXC = 4096;

  logic                  clk_50MHz = 1'b0;
  logic                  rst_n;
  logic                  play;
  logic                  stop;
  logic                  loop;
  logic [ADDR_W-1:0]     note_addr;
  logic                  note_rd;
  logic [HP_W+DUR_W-1:0] note_data;
  logic                  speaker;
  logic                  busy;
  logic                  done;

  logic [31:0] rom [0:7];

  melody_player #(
    .CLK_FREQ(100_000), .ADDR_W(ADDR_W), .HP_W(HP_W), .DUR_W(DUR_W), .GAP_MS(1)
  ) dut (
    .clk_50MHz(clk_50MHz), .rst_n(rst_n), .play(play), .stop(stop), .loop(loop),
    .note_addr(note_addr), .note_rd(note_rd), .note_data(note_data),
    .speaker(speaker), .busy(busy), .done(done)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  // synchronous note ROM
  always @(posedge clk_50MHz)
    if (note_rd) note_data <= rom[note_addr];

  int errors = 0;
  int checks = 0;

  // expected {addr[6:4], rd, spk, busy, done} per cycle after the play rise
  logic [6:0] exp_v [0:MAXC-1];
  int         rel = 0;
  bit         chk_en = 0;
  int         chk_len = 0;
  logic [2:0] m_addr;

  function automatic logic [6:0] pk(int a, bit rd, bit spk, bit bz, bit dn);
    return {3'(a), rd, spk, bz, dn};
  endfunction

  function automatic void put(int idx, logic [6:0] v);
    if (idx >= 0 && idx < MAXC) exp_v[idx] = v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // song timeline: 4 idle cycles, then FETCH/LOAD, note, gap, advance; end/loop rules
  task automatic build(input bit lp, input int stop_at, input int len);
    int r, a, hp, dur;
    bit fin;
    for (int i = 0; i < MAXC; i++) exp_v[i] = pk(m_addr, 0, 0, 0, 0);
    r = 4; a = 0; fin = 0;
    while (!fin && r < len) begin
      put(r, pk(a, 1, 0, 1, 0));
      put(r + 1, pk(a, 0, 0, 1, 0));
      hp  = int'(rom[a][31:12]);
      dur = int'(rom[a][11:0]);
      r += 2;
      if (dur != 0) begin
        for (int j = 0; j < dur * TPM; j++)
          put(r + j, pk(a, 0, (hp != 0) ? (((j / ((hp != 0) ? hp : 1)) % 2) == 1) : 1'b0, 1, 0));
        r += dur * TPM;
        for (int j = 0; j < GAP * TPM; j++) put(r + j, pk(a, 0, 0, 1, 0));
        r += GAP * TPM;
      end
      if (dur == 0 || a == 7) begin
        if (lp) a = 0;
        else fin = 1;
      end else begin
        a++;
      end
    end
    if (fin) begin
      put(r, pk(a, 0, 0, 0, 1));
      for (int i = r + 1; i < MAXC; i++) put(i, pk(a, 0, 0, 0, 0));
      m_addr = 3'(a);
    end
    if (stop_at > 0) begin
      m_addr = exp_v[stop_at - 1][6:4];
      for (int i = stop_at; i < MAXC; i++) put(i, pk(m_addr, 0, 0, 0, 0));
    end
  endtask

  always @(posedge clk_50MHz)
    if (chk_en) rel = rel + 1;

  // per-cycle comparison against the model
  always @(negedge clk_50MHz) begin
    if (chk_en && rel < chk_len) begin
      checks++;
      if ({note_addr, note_rd, speaker, busy, done} !== exp_v[rel]) begin
        errors++;
        $display("FAIL cycle r=%0d got addr=%0d rd=%b spk=%b busy=%b done=%b exp addr=%0d rd=%b spk=%b busy=%b done=%b",
                 rel, note_addr, note_rd, speaker, busy, done,
                 exp_v[rel][6:4], exp_v[rel][3], exp_v[rel][2], exp_v[rel][1], exp_v[rel][0]);
      end
    end
  end

  task automatic run(input bit lp, input int stop_at, input int len);
    build(lp, stop_at, len);
    loop = lp;
    @(posedge clk_50MHz); #1;
    play = 1'b1; rel = 0; chk_len = len; chk_en = 1;
    for (int r = 1; r < len; r++) begin
      @(posedge clk_50MHz); #1;
      if (r == 6) play = 1'b0;
      stop = (stop_at > 0 && r == stop_at - 1);
    end
    @(negedge clk_50MHz); #1;
    chk_en = 0; stop = 1'b0;
    repeat (6) @(posedge clk_50MHz);
  endtask

  task automatic load_t1();
    for (int i = 0; i < 8; i++) rom[i] = '0;
    rom[0] = {20'd10, 12'd2};
  endtask

  initial begin
    rst_n = 1'b0; play = 1'b0; stop = 1'b0; loop = 1'b0; m_addr = '0;
    for (int i = 0; i < 8; i++) rom[i] = '0;
    repeat (3) @(posedge clk_50MHz);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_spk",  32'(speaker), 0);
    check("rst_rd",   32'(note_rd), 0);
    check("rst_addr", 32'(note_addr), 0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk_50MHz);

    // T1: single tone then end marker
    load_t1();
    run(0, 0, 320);
    check("t1_rd_at4",    32'(exp_v[4][3]), 1);
    check("t1_spk15",     32'(exp_v[15][2]), 0);
    check("t1_spk16",     32'(exp_v[16][2]), 1);
    check("t1_spk205",    32'(exp_v[205][2]), 1);
    check("t1_spk206",    32'(exp_v[206][2]), 0);
    check("t1_busy307",   32'(exp_v[307][1]), 1);
    check("t1_done308",   32'(exp_v[308][0]), 1);
    check("t1_busy308",   32'(exp_v[308][1]), 0);

    // T2: rest, short tone, end marker
    for (int i = 0; i < 8; i++) rom[i] = '0;
    rom[0] = {20'd0, 12'd3};
    rom[1] = {20'd4, 12'd1};
    run(0, 0, 620);
    check("t2_rest300",   32'(exp_v[300][2]), 0);
    check("t2_addr406",   32'(exp_v[406][6:4]), 1);
    check("t2_spk411",    32'(exp_v[411][2]), 0);
    check("t2_spk412",    32'(exp_v[412][2]), 1);
    check("t2_done610",   32'(exp_v[610][0]), 1);

    // T3: loop over the T1 song, stopped later
    load_t1();
    run(1, 780, 800);
    check("t3_refetch",   32'(exp_v[308]), 32'({3'd0, 4'b1010}));
    check("t3_spk320",    32'(exp_v[320][2]), 1);

    // T4: eight notes, no end marker
    for (int i = 0; i < 8; i++) rom[i] = {20'(i + 1), 12'd1};
    run(0, 0, 1630);
    check("t4_spk6",      32'(exp_v[6][2]), 0);
    check("t4_spk7",      32'(exp_v[7][2]), 1);
    check("t4_done1620",  32'(exp_v[1620]), 32'({3'd7, 4'b0001}));
    run(1, 1700, 1720);
    check("t4_wrap1620",  32'(exp_v[1620]), 32'({3'd0, 4'b1010}));

    // T5: stop at note cycle 50, then a fresh start
    load_t1();
    run(0, 57, 100);
    check("t5_busy56",    32'(exp_v[56][1]), 1);
    check("t5_idle57",    32'(exp_v[57][2:0]), 0);
    run(0, 0, 320);

    // stop coincident with the start edge discards the start
    run(0, 4, 30);
    check("st_idle4",     32'(exp_v[4][3:0]), 0);

    // T6: async reset mid-GAP with play held high through release
    load_t1();
    loop = 1'b0;
    @(posedge clk_50MHz); #1;
    play = 1'b1;
    repeat (250) @(posedge clk_50MHz);
    #2;
    check("t6_busy_gap",  32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",  32'(busy), 0);
    check("t6_rst_spk",   32'(speaker), 0);
    check("t6_rst_rd",    32'(note_rd), 0);
    check("t6_rst_done",  32'(done), 0);
    check("t6_rst_addr",  32'(note_addr), 0);
    repeat (3) @(posedge clk_50MHz);
    #2;
    rst_n = 1'b1;
    m_addr = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_50MHz);
      check("t6_held_idle", 32'({busy, note_rd}), 0);
    end
    play = 1'b0;
    repeat (6) @(posedge clk_50MHz);
    run(0, 0, 320);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
